// File: rtl/data_mem_ls.sv
// Word-organised data memory with RV32I byte/half/word load-store and fixed response latency.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses instead of masking the low address bits.
module data_mem_ls #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_next_cnt;
    logic                   w_accept;
    logic                   w_enter_resp;

    logic                   r_we;
    logic [2:0]             r_funct3;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [31:0]            r_wdata;

    logic [31:0]            r_mem [DEPTH];

    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic                   r_rsp_err;
    logic [31:0]            r_rsp_rdata;

    logic                   w_we;
    logic [2:0]             w_funct3;
    logic [ADDR_SIZE-1:0]   w_addr;
    logic [31:0]            w_wdata;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_oob;
    logic                   w_f3_err;
    logic                   w_mis;
    logic                   w_err;
    logic [31:0]            w_rd_word;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [31:0]            w_ld_data;
    logic [31:0]            w_wr_word;

    // Next-state and wait counter
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    if (LATENCY == 0) begin
                        w_next_state = S_RESP;
                    end else begin
                        w_next_state = S_WAIT;
                        w_next_cnt   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_next_state == S_RESP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    // With zero latency the access happens on the accept edge, before the fields are registered
    assign w_we     = (r_state == S_IDLE) ? req_we     : r_we;
    assign w_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;
    assign w_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
    assign w_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;

    assign w_idx = w_addr[IDX_W+1:2];
    assign w_oob = (w_addr >> (IDX_W + 2)) != '0;

    always_comb begin
        w_f3_err = 1'b1;
        case (w_funct3)
            3'b000, 3'b001, 3'b010: w_f3_err = 1'b0;
            3'b100, 3'b101:         w_f3_err = w_we;
            default:                w_f3_err = 1'b1;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_mis = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                   ((w_funct3 == 3'b010) && (w_addr[1:0] != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    assign w_err     = w_oob || w_f3_err || w_mis;
    assign w_rd_word = r_mem[w_idx];
    assign w_byte    = w_rd_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half    = w_rd_word[{w_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_data = '0;
        case (w_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_ld_data = w_rd_word;
            3'b100:  w_ld_data = {24'b0, w_byte};
            3'b101:  w_ld_data = {16'b0, w_half};
            default: w_ld_data = '0;
        endcase
    end

    // Read-modify-write merge of the addressed lanes
    always_comb begin
        w_wr_word = w_rd_word;
        case (w_funct3[1:0])
            2'b00:   w_wr_word[{w_addr[1:0], 3'b000} +: 8] = w_wdata[7:0];
            2'b01:   w_wr_word[{w_addr[1], 4'b0000} +: 16] = w_wdata[15:0];
            2'b10:   w_wr_word = w_wdata;
            default: w_wr_word = w_rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[IDX_W'(i)] <= '0;
            end
        end else if (w_enter_resp && w_we && !w_err) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_req_ready <= (w_next_state == S_IDLE);
            r_rsp_valid <= w_enter_resp;
            r_rsp_err   <= w_enter_resp && w_err;
            r_rsp_rdata <= (w_enter_resp && !w_err && !w_we) ? w_ld_data : '0;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/data_mem_ls.md
DATA_MEM_LS -- requirements
Module: data_mem_ls

Interface
REQ-001 Parameters SHALL be: DEPTH, default 1024, number of 32-bit words (power of 2, >=4).
REQ-002 Parameters SHALL be: ADDR_SIZE, default 32, byte-address width.
REQ-003 Parameters SHALL be: LATENCY, default 1, wait cycles between acceptance and response (0..15).
REQ-004 Port clk SHALL be input, 1 bit, clock; all state changes on its rising edge.
REQ-005 Port rst SHALL be input, 1 bit, reset, synchronous, active-low.
REQ-006 Port req_valid SHALL be input, 1 bit, request present.
REQ-007 Port req_ready SHALL be output, 1 bit, block can accept a request.
REQ-008 Port req_we SHALL be input, 1 bit, 1 = store, 0 = load.
REQ-009 Port req_funct3 SHALL be input, 3 bits, RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 Port req_addr SHALL be input, ADDR_SIZE bits, byte address.
REQ-011 Port req_wdata SHALL be input, 32 bits, store data, right-aligned.
REQ-012 Port rsp_valid SHALL be output, 1 bit, one-cycle response strobe.
REQ-013 Port rsp_rdata SHALL be output, 32 bits, extended load data; 0 for stores and errors.
REQ-014 Port rsp_err SHALL be output, 1 bit, access fault, valid with rsp_valid.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 Accept = req_valid & req_ready; request fields SHALL be registered on accept, req inputs ignored elsewhere.
REQ-017 IDLE -> WAIT on accept when LATENCY>0; IDLE -> RESP on accept when LATENCY=0.
REQ-018 WAIT SHALL load a counter with LATENCY-1 on entry, decrement each cycle, go to RESP when counter = 0.
REQ-019 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; a new request is accepted no earlier than the cycle after RESP.
REQ-020 Load-to-rsp_valid latency SHALL be LATENCY+1 cycles after accept edge.
REQ-021 Word index SHALL be addr[log2(DEPTH)+1:2]; byte lane addr[1:0], half lane addr[1].
REQ-022 Any byte address >= 4*DEPTH SHALL give rsp_err=1, no write, rsp_rdata=0.
REQ-023 Reserved funct3 (011, 110, 111, or 1xx with req_we=1) SHALL give rsp_err=1, no write.
REQ-024 Stores SHALL commit in the cycle entering RESP, updating only addressed lanes (SB 1 byte, SH 2, SW 4).
REQ-025 Loads SHALL read the word at RESP entry: B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-026 A load in RESP SHALL observe any store committed in an earlier RESP.
REQ-027 Outputs rsp_valid, rsp_err SHALL be 0 and rsp_rdata 0 in every cycle outside RESP.

Reset
REQ-028 rst=0 at a clock edge SHALL clear all DEPTH words (index 0..DEPTH-1 inclusive) to 0, force IDLE, counter to 0.
REQ-029 rst=0 mid-transaction SHALL abort it: no write, no rsp_valid; req_ready=1 the cycle after rst returns to 1.
REQ-030 During reset rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL give rsp_err=1, no write, rsp_rdata=0.
REQ-032 Macro DMEM_MISALIGN_TRAP_EN undefined: misaligned low bits SHALL be masked (H: addr[0]=0, W: addr[1:0]=0) and the access performed, rsp_err=0.

Verification
REQ-033 Reset then LW at 0x0FFC (DEPTH=1024) -> rsp_rdata=0x00000000, rsp_err=0 (last word cleared).
REQ-034 SW 0x80FF7F01 @0x10; LB @0x10 -> 0x00000001; LB @0x11 -> 0x0000007F; LB @0x12 -> 0xFFFFFFFF; LBU @0x12 -> 0x000000FF; LH @0x12 -> 0xFFFF80FF.
REQ-035 SW 0x11223344 @0x20; SB 0xAA @0x21; SH 0xBEEF @0x22; LW @0x20 -> 0xBEEFAA44.
REQ-036 LATENCY=3: LW accepted at cycle N -> rsp_valid high only at cycle N+4, req_ready low N+1..N+4.
REQ-037 LW @0x1000 -> rsp_err=1, rsp_rdata=0; LW @0x22: with DMEM_MISALIGN_TRAP_EN rsp_err=1, without -> data of word @0x20.
REQ-038 SW 0x55 @0x30 with rst=0 asserted in WAIT -> no rsp_valid; LW @0x30 after reset -> 0x00000000.
